// File: rtl/lut_pkg.sv
// Shared types and sizes for the 8-entry, 1-bit LUT ROM and its scan sequencer.
package lut_pkg;

    localparam int unsigned LUT_ADDR_W = 3;
    localparam int unsigned LUT_DEPTH  = 2 ** LUT_ADDR_W;
    localparam int unsigned LUT_CNT_W  = LUT_ADDR_W + 1;

    typedef logic [LUT_ADDR_W-1:0] lut_addr_t;
    typedef logic [LUT_DEPTH-1:0]  lut_word_t;
    typedef logic [LUT_CNT_W-1:0]  lut_cnt_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } scan_state_e;

endpackage : lut_pkg

// File: rtl/lut_scan_sequencer_if.sv
// Downstream valid/ready result bus of the LUT scan sequencer.
interface lut_scan_sequencer_if #(
    parameter int unsigned WORD_W = lut_pkg::LUT_DEPTH
);
    logic [WORD_W-1:0] out_word;
    logic              out_valid;
    logic              out_ready;

    modport master (output out_word, output out_valid, input out_ready);
    modport slave  (input out_word, input out_valid, output out_ready);

endinterface : lut_scan_sequencer_if

// File: rtl/lut_scan_sequencer.sv
// Sweeps a modulo-8 window of LUT addresses, packs the returned bits into a word
// and offers it downstream on a valid/ready handshake.
module lut_scan_sequencer
    import lut_pkg::*;
#(
    parameter int unsigned ADDR_W = LUT_ADDR_W,
    parameter int unsigned WORD_W = LUT_DEPTH,
    parameter int unsigned CNT_W  = LUT_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    start_addr,
    input  logic [CNT_W-1:0]     count,
    output logic [ADDR_W-1:0]    lut_addr,
    input  logic                 lut_data,
    lut_scan_sequencer_if.master out_if,
    output logic                 busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    scan_state_e       r_state;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_lut_addr;
    logic [CNT_W-1:0]  r_n;
    logic [CNT_W-1:0]  r_idx;
    logic [WORD_W-1:0] r_shift;
    logic [WORD_W-1:0] r_out_word;
    logic              r_out_valid;
    logic              r_busy;

    logic [CNT_W-1:0]  w_n;
    logic [WORD_W-1:0] w_shift_next;
    logic              w_last;

    // Zero and out-of-range counts both mean a full sweep.
    assign w_n = ((count == '0) || (count > CNT_W'(DEPTH))) ? CNT_W'(DEPTH) : count;

    assign w_shift_next = lut_data ? (r_shift | (WORD_W'(1) << r_idx)) : r_shift;
    assign w_last       = (r_idx == (r_n - CNT_W'(1)));

    // The first SCAN cycle (busy still low) presents the base address; each
    // following cycle captures one bit and advances the address.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_base      <= '0;
            r_lut_addr  <= '0;
            r_n         <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_out_word  <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_base  <= start_addr;
                        r_n     <= w_n;
                        r_idx   <= '0;
                        r_shift <= '0;
                        r_state <= SCAN;
                    end
                end
                SCAN: begin
                    if (!r_busy) begin
                        r_lut_addr <= r_base;
                        r_busy     <= 1'b1;
                    end else begin
                        r_shift    <= w_shift_next;
                        r_lut_addr <= r_lut_addr + ADDR_W'(1);
                        r_idx      <= r_idx + CNT_W'(1);
                        if (w_last) begin
                            r_out_word  <= w_shift_next;
                            r_out_valid <= 1'b1;
                            r_state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_if.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign lut_addr         = r_lut_addr;
    assign busy             = r_busy;
    assign out_if.out_word  = r_out_word;
    assign out_if.out_valid = r_out_valid;

endmodule : lut_scan_sequencer

// File: doc/lut_scan_sequencer.md
Name: lut_scan_sequencer

Overview:
- Upstream address-generation stage for the team's 8-entry, 1-bit combinational LUT ROM.
- On a start request, sweeps a programmable window of LUT addresses (modulo-8 wrap), one per cycle.
- Captures the returned 1-bit data each cycle, packs the bits into a word, and presents it downstream on a valid/ready handshake.

Parameters:
- ADDR_W, 3, LUT address width; depth = 2**ADDR_W.
- WORD_W, 8, output word width; must equal 2**ADDR_W.
- CNT_W, 4, width of the count input; holds values 0..2**ADDR_W.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst_n  input  1  synchronous reset, active-low.
- start  input  1  scan request; sampled only in IDLE.
- start_addr  input  ADDR_W  first LUT address of the window.
- count  input  CNT_W  number of entries to read; 0 means full sweep (2**ADDR_W).
- lut_addr  output  ADDR_W  address driven to the LUT ROM; registered.
- lut_data  input  1  LUT ROM output; combinational from lut_addr.
- out_word  output  WORD_W  packed result; registered.
- out_valid  output  1  out_word valid.
- out_ready  input  1  downstream accepts out_word.
- busy  output  1  high from the cycle after start acceptance until the handshake completes.

Behaviour:
- Reset (rst_n=0 at a clk edge), from any state including mid-scan:
  - FSM goes to IDLE.
  - lut_addr=0, out_word=0, out_valid=0, busy=0.
  - Internal shift register and counter are cleared.
- FSM states: IDLE, SCAN, HOLD.
- IDLE:
  - If start=1 at edge T, latch start_addr and N, where N = count, or 2**ADDR_W if count=0.
  - Count values above 2**ADDR_W saturate to 2**ADDR_W.
  - Go to SCAN: lut_addr=start_addr, busy=1, from T+1.
  - If start=0, stay in IDLE; lut_addr holds its last value.
- SCAN, scan index i = 0..N-1:
  - Each cycle, lut_data is captured into bit i of the internal word.
  - lut_addr increments modulo 2**ADDR_W, so address 7 wraps to 0.
  - After the N-th capture (edge T+N+1): move to HOLD.
  - out_word = packed bits, with bit i = LUT[(start_addr+i) mod 8] and bits N..WORD_W-1 = 0.
  - out_valid=1 from T+N+1.
  - Latency from start acceptance to out_valid: N+1 cycles.
- HOLD:
  - out_word and out_valid stay stable while out_ready=0.
  - On out_valid & out_ready at an edge, go to IDLE: out_valid=0, busy=0, out_word retains its value.
- start while in SCAN or HOLD is ignored and not queued.
- start in the same cycle as the HOLD handshake is ignored; a new start is honoured only in IDLE, i.e. one cycle later at the earliest.
- Inputs start_addr and count are sampled only at acceptance; later changes have no effect on the scan in progress.
- out_ready is ignored outside HOLD.
- No X propagation: every register has a defined reset value.

Decomposition:
- Shared package lut_pkg:
  - LUT_ADDR_W=3 and LUT_DEPTH=8.
  - Typedefs lut_addr_t and lut_word_t.
  - Enum scan_state_e {IDLE, SCAN, HOLD}.
- No sub-module required; the FSM, counter and shift register sit in one module.
- The bench instantiates the existing LUT ROM, contents 8'hB9, as the lut_data source.

Test Plan:
- Reset, then start=1, start_addr=0, count=8 -> lut_addr walks 0..7 on cycles T+1..T+8; out_valid at T+9; out_word=8'hB9; busy high through the handshake.
- start_addr=6, count=4 (wrap) -> addresses 6,7,0,1; out_word=8'h06; out_valid 5 cycles after acceptance.
- start_addr=3, count=0 (full sweep) -> addresses 3..7,0..2; out_word=8'h37.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_word and out_valid held constant; out_ready=1 -> out_valid drops next edge; start pulses during SCAN/HOLD cause no second result.
- Reset mid-operation: rst_n=0 during the third SCAN cycle -> next edge: IDLE, all outputs 0; a following scan with start_addr=0, count=2 returns out_word=8'h01.
- Back-to-back: start held high across the handshake -> the new scan begins one cycle after the return to IDLE, using the start_addr/count sampled that cycle.
